apb_cmd_master: RTL and testbench

APB4 requester (initiator) that turns a simple valid/ready command stream into APB transfers toward the timer's APB slave port.
- Buffers one pending command.
- Sequences IDLE/SETUP/ACCESS.
- Waits for pready and returns prdata/pslverr on a valid/ready response port.
- Used by the bench-side CPU model and by the on-chip config sequencer.

---
 rtl/apb_cmd_master.sv | 191 +++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   APB4 requester: accepts commands on a valid/ready stream, holds one in a
//   single-entry buffer, runs it as an IDLE -> SETUP -> ACCESS transfer and
//   returns read data / slave error on a valid/ready response port.
//
//   Optional build macro: APB_CMD_MASTER_TIMEOUT_EN
//     When defined, an ACCESS phase that sees pready low for TIMEOUT_CYCLES
//     cycles is abandoned and answered with rsp_err=1, rsp_rdata=0.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready = buffer free)
//   cmd_write/addr/wdata/strb      command payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err              response payload (rdata is 0 for writes)
//   psel/penable/pwrite/paddr      APB requester outputs
//   pwdata/pstrb
//   prdata/pready/pslverr          APB completer inputs
module apb_cmd_master #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t state, state_nxt;

  logic              buf_valid;
  logic              buf_write;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [STRB_W-1:0] buf_strb;

  logic start;
  logic done;
  logic abort;
  logic timeout_hit;
  logic accept;

  // cmd_ready is kept as its own register; the buffer is full exactly when
  // it is low.
  assign buf_valid = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts ACCESS cycles with pready low; the cycle that would bring it to
  // TIMEOUT_CYCLES is the last one waited. A pready in that cycle completes
  // the transfer normally because pready is checked first in the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_SETUP) begin
      wait_cnt <= '0;
    end else if (state == S_ACCESS && !pready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == S_ACCESS) && !pready && (wait_cnt == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        // An unconsumed response blocks the next transfer, so a capture can
        // never collide with a consume.
        if (buf_valid && (!rsp_valid || rsp_ready)) begin
          start     = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      buf_write <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      buf_strb  <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // accept requires an empty buffer and start a full one, so the two
      // never fire on the same edge.
      if (accept) begin
        cmd_ready <= 1'b0;
        buf_write <= cmd_write;
        buf_addr  <= cmd_addr;
        buf_wdata <= cmd_wdata;
        buf_strb  <= cmd_strb;
      end else if (start) begin
        cmd_ready <= 1'b1;
      end

      psel    <= (state_nxt != S_IDLE);
      penable <= (state_nxt == S_ACCESS);

      if (start) begin
        pwrite <= buf_write;
        paddr  <= buf_addr;
        pwdata <= buf_write ? buf_wdata : '0;
        pstrb  <= buf_write ? buf_strb  : '0;
      end

      if (done) begin
        rsp_valid <= 1'b1;
        rsp_err   <= pslverr;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (abort) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master
//   Self-checking bench for apb_cmd_master. Commands and the responses the
//   APB completer will give are chosen by the bench; a command queue and a
//   response queue hold what the APB bus and the response port must show.
module tb_apb_cmd_master;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned TMO    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready, pslverr;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.write = 1'($urandom);
    c.addr  = ADDR_W'($urandom);
    c.wdata = $urandom;
    c.strb  = STRB_W'($urandom);
    return c;
  endfunction

  // Offer a command that must be taken at the next edge.
  task automatic offer(input cmd_t c);
    chk("cmd_ready_before_offer", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    cmd_strb  = c.strb;
    cmd_q.push_back(c);
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = ADDR_W'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = STRB_W'($urandom);
    chk("cmd_ready_after_accept", cmd_ready, 0);
  endtask

  task automatic chk_bus(input string ph, input cmd_t c, input logic en);
    chk({ph, "_psel"}, psel, 1);
    chk({ph, "_penable"}, penable, 32'(en));
    chk({ph, "_paddr"}, 32'(paddr), 32'(c.addr));
    chk({ph, "_pwrite"}, pwrite, 32'(c.write));
    chk({ph, "_pwdata"}, pwdata, c.write ? c.wdata : 32'h0);
    chk({ph, "_pstrb"}, 32'(pstrb), c.write ? 32'(c.strb) : 32'h0);
  endtask

  // Called in the SETUP cycle of the oldest queued command. The completer
  // inserts 'waits' cycles of pready=0 and then answers with err/rdata.
  task automatic serve(input int unsigned waits, input logic err, input logic [DATA_W-1:0] rdata);
    cmd_t c;
    rsp_t r;
    c = cmd_q.pop_front();
    chk_bus("setup", c, 1'b0);
    tick();
    for (int unsigned w = 0; w <= waits; w++) begin
      chk_bus("access", c, 1'b1);
      if (w == waits) begin
        pready  = 1'b1;
        prdata  = rdata;
        pslverr = err;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
      tick();
    end
    pready  = 1'b0;
    prdata  = $urandom;
    pslverr = 1'($urandom);
    chk("end_psel", psel, 0);
    chk("end_penable", penable, 0);
    chk("end_rsp_valid", rsp_valid, 1);
    r.data = c.write ? '0 : rdata;
    r.err  = err;
    rsp_q.push_back(r);
  endtask

  task automatic take_rsp();
    rsp_t r;
    r = rsp_q.pop_front();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, r.data);
    chk("rsp_err", rsp_err, 32'(r.err));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_consume", rsp_valid, 0);
  endtask

  initial begin
    cmd_t c, c2;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", 32'(pstrb), 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    tick();

    // Write, pready on the second ACCESS cycle
    c = '{1'b1, 12'h000, 32'h0000_0103, 4'hF};
    offer(c);
    chk("idle_after_accept_psel", psel, 0);
    tick();
    serve(1, 1'b0, 32'hCAFE_0001);
    take_rsp();

    // Read
    c = '{1'b0, 12'h004, 32'h1234_5678, 4'hF};
    offer(c);
    tick();
    serve(1, 1'b0, 32'hDEAD_BEEF);
    take_rsp();

    // Slave error, then a normal command
    c = '{1'b1, 12'h000, 32'h5555_AAAA, 4'h3};
    offer(c);
    tick();
    serve(1, 1'b1, 32'h0);
    take_rsp();
    c = '{1'b1, 12'h008, 32'h0000_00FF, 4'h1};
    offer(c);
    tick();
    serve(0, 1'b0, 32'h0);
    take_rsp();

    // Back-to-back with the response slot held
    c  = '{1'b0, 12'h010, 32'h0, 4'h0};
    c2 = '{1'b1, 12'h014, 32'hA5A5_5A5A, 4'hC};
    offer(c);
    tick();
    chk("b2b_cmd_ready_in_setup", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = c2.write; cmd_addr = c2.addr; cmd_wdata = c2.wdata; cmd_strb = c2.strb;
    cmd_q.push_back(c2);
    serve(1, 1'b0, 32'h0BAD_F00D);
    cmd_write = 1'b0; cmd_addr = 12'hFFF; cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_hold_psel", psel, 0);
      chk("b2b_hold_cmd_ready", cmd_ready, 0);
      chk("b2b_hold_rsp_valid", rsp_valid, 1);
      chk("b2b_hold_rsp_rdata", rsp_rdata, rsp_q[0].data);
      tick();
    end
    cmd_valid = 1'b0;
    take_rsp();
    serve(2, 1'b0, 32'h0);
    take_rsp();

    // Randomised transfers
    for (int n = 0; n < 24; n++) begin
      c = rand_cmd();
      offer(c);
      tick();
      serve($urandom_range(4, 0), 1'($urandom), $urandom);
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
        chk("rand_hold_rsp_valid", rsp_valid, 1);
        chk("rand_hold_psel", psel, 0);
        tick();
      end
      take_rsp();
    end

    // Completer never answers
    c = '{1'b1, 12'h020, 32'h1111_2222, 4'hF};
    offer(c);
    tick();
    chk_bus("tmo_setup", c, 1'b0);
    tick();
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    for (int i = 0; i < int'(TMO); i++) begin
      chk("tmo_wait_psel", psel, 1);
      chk("tmo_wait_penable", penable, 1);
      prdata = $urandom;
      pslverr = 1'b0;
      tick();
    end
    chk("tmo_abort_psel", psel, 0);
    chk("tmo_abort_penable", penable, 0);
    cmd_q.delete();
    rsp_q.push_back('{32'h0, 1'b1});
    take_rsp();
`else
    for (int i = 0; i < 100; i++) begin
      chk("hang_psel", psel, 1);
      chk("hang_penable", penable, 1);
      prdata = $urandom;
      pslverr = 1'($urandom);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("hang_rst_psel", psel, 0);
    cmd_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
`endif

    // Reset during ACCESS with a second command buffered
    c  = '{1'b0, 12'h030, 32'h0, 4'h0};
    c2 = '{1'b1, 12'h034, 32'h7777_8888, 4'hF};
    offer(c);
    tick();
    cmd_valid = 1'b1;
    cmd_write = c2.write; cmd_addr = c2.addr; cmd_wdata = c2.wdata; cmd_strb = c2.strb;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_psel", psel, 1);
    chk("mid_penable", penable, 1);
    chk("mid_cmd_ready", cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_psel", psel, 0);
    chk("async_rst_penable", penable, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_cmd_ready", cmd_ready, 1);
    cmd_q.delete();
    rsp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_no_stale_psel", psel, 0);
    c = '{1'b0, 12'h044, 32'h0, 4'h0};
    offer(c);
    tick();
    serve(1, 1'b0, 32'h1357_9BDF);
    take_rsp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
